// File: rtl/rng_pkg.sv
// Shared types and LFSR tap table for the multi-channel stimulus bank.
// Tap masks are for the right-shifting Galois form: tap n of the table lands on bit n-1.
package rng_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    STEP  = 2'd2,
    BURST = 2'd3
  } rng_mode_e;

  typedef enum logic {
    BURST_IDLE   = 1'b0,
    BURST_ACTIVE = 1'b1
  } burst_state_e;

  localparam int BURST_CNT_W = 16;

  function automatic logic [63:0] tap_bit(int n);
    return 64'd1 << (n - 1);
  endfunction

  // Maximal-length tap sets, XAPP052 table.
  function automatic logic [63:0] lfsr_taps(int width);
    logic [63:0] m;
    m = '0;
    case (width)
      4:  m = tap_bit(4)  | tap_bit(3);
      5:  m = tap_bit(5)  | tap_bit(3);
      6:  m = tap_bit(6)  | tap_bit(5);
      7:  m = tap_bit(7)  | tap_bit(6);
      8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
      9:  m = tap_bit(9)  | tap_bit(5);
      10: m = tap_bit(10) | tap_bit(7);
      11: m = tap_bit(11) | tap_bit(9);
      12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
      14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
      15: m = tap_bit(15) | tap_bit(14);
      16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: m = tap_bit(17) | tap_bit(14);
      18: m = tap_bit(18) | tap_bit(11);
      19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      20: m = tap_bit(20) | tap_bit(17);
      21: m = tap_bit(21) | tap_bit(19);
      22: m = tap_bit(22) | tap_bit(21);
      23: m = tap_bit(23) | tap_bit(18);
      24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: m = tap_bit(25) | tap_bit(22);
      26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
      28: m = tap_bit(28) | tap_bit(25);
      29: m = tap_bit(29) | tap_bit(27);
      30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      31: m = tap_bit(31) | tap_bit(28);
      32: m = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
      33: m = tap_bit(33) | tap_bit(20);
      34: m = tap_bit(34) | tap_bit(27) | tap_bit(2)  | tap_bit(1);
      35: m = tap_bit(35) | tap_bit(33);
      36: m = tap_bit(36) | tap_bit(25);
      37: m = tap_bit(37) | tap_bit(5)  | tap_bit(4)  | tap_bit(3) | tap_bit(2) | tap_bit(1);
      38: m = tap_bit(38) | tap_bit(6)  | tap_bit(5)  | tap_bit(1);
      39: m = tap_bit(39) | tap_bit(35);
      40: m = tap_bit(40) | tap_bit(38) | tap_bit(21) | tap_bit(19);
      41: m = tap_bit(41) | tap_bit(38);
      42: m = tap_bit(42) | tap_bit(41) | tap_bit(20) | tap_bit(19);
      43: m = tap_bit(43) | tap_bit(42) | tap_bit(38) | tap_bit(37);
      44: m = tap_bit(44) | tap_bit(43) | tap_bit(18) | tap_bit(17);
      45: m = tap_bit(45) | tap_bit(44) | tap_bit(42) | tap_bit(41);
      46: m = tap_bit(46) | tap_bit(45) | tap_bit(26) | tap_bit(25);
      47: m = tap_bit(47) | tap_bit(42);
      48: m = tap_bit(48) | tap_bit(47) | tap_bit(21) | tap_bit(20);
      49: m = tap_bit(49) | tap_bit(40);
      50: m = tap_bit(50) | tap_bit(49) | tap_bit(24) | tap_bit(23);
      51: m = tap_bit(51) | tap_bit(50) | tap_bit(36) | tap_bit(35);
      52: m = tap_bit(52) | tap_bit(49);
      53: m = tap_bit(53) | tap_bit(52) | tap_bit(38) | tap_bit(37);
      54: m = tap_bit(54) | tap_bit(53) | tap_bit(18) | tap_bit(17);
      55: m = tap_bit(55) | tap_bit(31);
      56: m = tap_bit(56) | tap_bit(55) | tap_bit(35) | tap_bit(34);
      57: m = tap_bit(57) | tap_bit(50);
      58: m = tap_bit(58) | tap_bit(39);
      59: m = tap_bit(59) | tap_bit(58) | tap_bit(38) | tap_bit(37);
      60: m = tap_bit(60) | tap_bit(59);
      61: m = tap_bit(61) | tap_bit(60) | tap_bit(46) | tap_bit(45);
      62: m = tap_bit(62) | tap_bit(61) | tap_bit(6)  | tap_bit(5);
      63: m = tap_bit(63) | tap_bit(62);
      64: m = tap_bit(64) | tap_bit(63) | tap_bit(61) | tap_bit(60);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rng_stimulus_bank_if.sv
// Control and data bundle of the stimulus bank; master drives controls, slave is the bank.
interface rng_stimulus_bank_if
  import rng_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 32
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  rng_mode_e                mode;
  logic                     step;
  logic [NUM_CH-1:0]        ch_enable;
  logic                     seed_load;
  logic [SEL_W-1:0]         seed_ch;
  logic [WIDTH-1:0]         seed_value;
  logic [NUM_CH*WIDTH-1:0]  random_bus;
  logic                     valid;
  logic                     burst_busy;
  logic                     seed_zero_fix;

  modport master (
    output mode, step, ch_enable, seed_load, seed_ch, seed_value,
    input  random_bus, valid, burst_busy, seed_zero_fix
  );

  modport slave (
    input  mode, step, ch_enable, seed_load, seed_ch, seed_value,
    output random_bus, valid, burst_busy, seed_zero_fix
  );
endinterface

// File: rtl/rng_lfsr_channel.sv
// One Galois LFSR lane: reseedable, zero state never allowed in, load beats advance.
module rng_lfsr_channel
  import rng_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [63:0] SEED  = 64'd3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] state,
  output logic             zero_fix
);
  localparam logic [WIDTH-1:0] TAPS        = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] SEED_TRUNC  = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_STATE = (SEED_TRUNC == '0) ? WIDTH'(1) : SEED_TRUNC;

  logic [WIDTH-1:0] next_state;

  assign next_state = {1'b0, state[WIDTH-1:1]} ^ (state[0] ? TAPS : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RESET_STATE;
      zero_fix <= 1'b0;
    end else begin
      zero_fix <= 1'b0;
      if (load) begin
        if (load_value == '0) begin
          state    <= WIDTH'(1);
          zero_fix <= 1'b1;
        end else begin
          state <= load_value;
        end
      end else if (adv) begin
        state <= next_state;
      end
    end
  end

endmodule

// File: rtl/rng_stimulus_bank.sv
// Multi-channel LFSR stimulus source with run/hold/step/burst advance control.
//
//   state        | meaning
//   BURST_IDLE   | no burst running; step in BURST mode starts one
//   BURST_ACTIVE | burst running; one advance per cycle until the counter expires
module rng_stimulus_bank
  import rng_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int WIDTH     = 32,
  parameter int SEED_BASE = 3,
  parameter int SEED_STEP = 2,
  parameter int BURST_LEN = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  rng_stimulus_bank_if.slave   bus
);
  localparam logic [BURST_CNT_W-1:0] BURST_LOAD = BURST_CNT_W'(BURST_LEN);

  burst_state_e              state_q, state_d;
  logic [BURST_CNT_W-1:0]    cnt_q, cnt_d;
  logic                      adv;
  logic                      valid_q;
  logic [NUM_CH-1:0]         load_vec;
  logic [NUM_CH-1:0]         zero_fix_vec;
  logic [NUM_CH*WIDTH-1:0]   bus_flat;

  always_comb begin
    adv = 1'b0;
    case (bus.mode)
      RUN:     adv = 1'b1;
      HOLD:    adv = 1'b0;
      STEP:    adv = bus.step;
      BURST:   adv = (state_q == BURST_ACTIVE);
      default: adv = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BURST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Leaving BURST mode aborts immediately; step while active is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BURST_IDLE: begin
        if (bus.mode == BURST && bus.step) begin
          state_d = BURST_ACTIVE;
          cnt_d   = BURST_LOAD;
        end
      end
      BURST_ACTIVE: begin
        if (bus.mode != BURST) begin
          state_d = BURST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == BURST_CNT_W'(1)) state_d = BURST_IDLE;
        end
      end
      default: begin
        state_d = BURST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Out-of-range seed_ch matches no lane, so it never loads or strobes.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [63:0] CH_SEED = 64'(SEED_BASE) + 64'(c) * 64'(SEED_STEP);

    assign load_vec[c] = bus.seed_load && (int'(bus.seed_ch) == c);

    rng_lfsr_channel #(
      .WIDTH (WIDTH),
      .SEED  (CH_SEED)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .adv        (adv && bus.ch_enable[c]),
      .load       (load_vec[c]),
      .load_value (bus.seed_value),
      .state      (bus_flat[c*WIDTH +: WIDTH]),
      .zero_fix   (zero_fix_vec[c])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= (adv && (|bus.ch_enable)) || (|load_vec);
  end

  assign bus.random_bus    = bus_flat;
  assign bus.valid         = valid_q;
  assign bus.burst_busy    = (state_q == BURST_ACTIVE);
  assign bus.seed_zero_fix = |zero_fix_vec;

endmodule

// File: tb/tb_rng_stimulus_bank.sv
// Scoreboard bench: driver pushes model predictions per cycle, monitor pops and compares.
module tb_rng_stimulus_bank;
  import rng_pkg::*;

  typedef struct {
    logic [31:0] bus;
    logic        valid;
    logic        busy;
    logic        zfix;
  } exp_t;

  logic clk;
  logic reset;
  logic reset_b;

  int n_pass;
  int n_total;

  exp_t expq[$];

  logic [7:0] m_ch [4];
  logic       m_busy;
  int         m_left;

  rng_stimulus_bank_if #(.NUM_CH(4), .WIDTH(8)) bus_a ();
  rng_stimulus_bank_if #(.NUM_CH(6), .WIDTH(8)) bus_b ();

  rng_stimulus_bank #(
    .NUM_CH(4), .WIDTH(8), .SEED_BASE(3), .SEED_STEP(2), .BURST_LEN(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  rng_stimulus_bank #(
    .NUM_CH(6), .WIDTH(8), .SEED_BASE(3), .SEED_STEP(2), .BURST_LEN(4)
  ) dut6 (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] lfsr8(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  // Drive one cycle at the falling edge and predict what the next rising edge produces.
  task automatic cycle(input logic rst, input rng_mode_e m, input logic st,
                       input logic [3:0] en, input logic ld, input logic [1:0] sc,
                       input logic [7:0] sv);
    exp_t e;
    logic adv;
    @(negedge clk);
    reset                = rst;
    bus_a.mode           = m;
    bus_a.step           = st;
    bus_a.ch_enable      = en;
    bus_a.seed_load      = ld;
    bus_a.seed_ch        = sc;
    bus_a.seed_value     = sv;
    if (rst) begin
      for (int c = 0; c < 4; c++) m_ch[c] = 8'(3 + 2 * c);
      m_busy  = 1'b0;
      m_left  = 0;
      e.valid = 1'b0;
      e.zfix  = 1'b0;
    end else begin
      adv     = (m == RUN) || (m == STEP && st) || (m == BURST && m_busy);
      e.valid = ld || (adv && en != 4'b0);
      e.zfix  = ld && (sv == 8'h00);
      for (int c = 0; c < 4; c++) begin
        if (ld && int'(sc) == c)   m_ch[c] = (sv == 8'h00) ? 8'h01 : sv;
        else if (adv && en[c])     m_ch[c] = lfsr8(m_ch[c]);
      end
      if (m != BURST) begin
        m_busy = 1'b0;
        m_left = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end else if (st) begin
        m_busy = 1'b1;
        m_left = 4;
      end
    end
    e.bus  = {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
    e.busy = m_busy;
    expq.push_back(e);
  endtask

  task automatic run_cycles(input int n, input rng_mode_e m, input logic [3:0] en);
    for (int i = 0; i < n; i++) cycle(1'b0, m, 1'b0, en, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one prediction per rising edge the driver has covered.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("random_bus", 64'(bus_a.random_bus), 64'(e.bus));
        chk("valid", 64'(bus_a.valid), 64'(e.valid));
        chk("burst_busy", 64'(bus_a.burst_busy), 64'(e.busy));
        chk("seed_zero_fix", 64'(bus_a.seed_zero_fix), 64'(e.zfix));
      end
    end
  end

  initial begin
    rng_mode_e rm;
    int        drain;
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    reset_b = 1'b1;
    bus_a.mode = HOLD; bus_a.step = 1'b0; bus_a.ch_enable = 4'hF;
    bus_a.seed_load = 1'b0; bus_a.seed_ch = '0; bus_a.seed_value = '0;
    bus_b.mode = HOLD; bus_b.step = 1'b0; bus_b.ch_enable = 6'h3F;
    bus_b.seed_load = 1'b0; bus_b.seed_ch = '0; bus_b.seed_value = '0;

    for (int i = 0; i < 3; i++) cycle(1'b1, RUN, 1'b0, 4'hF, 1'b0, 2'd0, 8'h00);
    after_edge();
    chk("reset_seeds", 64'(bus_a.random_bus), 64'h09070503);
    chk("reset_valid", 64'(bus_a.valid), 64'd0);

    run_cycles(1, RUN, 4'hF);
    after_edge();
    chk("run_adv1_ch0", 64'(bus_a.random_bus[7:0]), 64'hB9);
    chk("run_adv1_valid", 64'(bus_a.valid), 64'd1);
    run_cycles(1, RUN, 4'hF);
    after_edge();
    chk("run_adv2_ch0", 64'(bus_a.random_bus[7:0]), 64'hE4);
    run_cycles(253, RUN, 4'hF);
    after_edge();
    chk("run_period_ch0", 64'(bus_a.random_bus[7:0]), 64'h03);

    run_cycles(10, HOLD, 4'hF);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, STEP, 1'b1, 4'hF, 1'b0, 2'd0, 8'h00);
      run_cycles(2, STEP, 4'hF);
    end

    cycle(1'b0, BURST, 1'b1, 4'hF, 1'b0, 2'd0, 8'h00);
    run_cycles(1, BURST, 4'hF);
    cycle(1'b0, BURST, 1'b1, 4'hF, 1'b0, 2'd0, 8'h00);
    run_cycles(6, BURST, 4'hF);
    cycle(1'b0, BURST, 1'b1, 4'hF, 1'b0, 2'd0, 8'h00);
    run_cycles(1, BURST, 4'hF);
    run_cycles(4, HOLD, 4'hF);

    cycle(1'b0, RUN, 1'b0, 4'hF, 1'b1, 2'd2, 8'h00);
    after_edge();
    chk("zero_seed_ch2", 64'(bus_a.random_bus[23:16]), 64'h01);
    run_cycles(2, RUN, 4'hF);
    cycle(1'b0, HOLD, 1'b0, 4'hF, 1'b1, 2'd1, m_ch[1]);
    cycle(1'b0, HOLD, 1'b0, 4'hF, 1'b1, 2'd3, 8'hA5);
    run_cycles(2, HOLD, 4'hF);

    run_cycles(5, RUN, 4'b0101);
    run_cycles(3, RUN, 4'b0000);
    run_cycles(2, STEP, 4'hF);

    cycle(1'b0, BURST, 1'b1, 4'hF, 1'b0, 2'd0, 8'h00);
    run_cycles(1, BURST, 4'hF);
    cycle(1'b1, BURST, 1'b0, 4'hF, 1'b1, 2'd0, 8'h33);
    after_edge();
    chk("reset_mid_burst_busy", 64'(bus_a.burst_busy), 64'd0);
    chk("reset_mid_burst_bus", 64'(bus_a.random_bus), 64'h09070503);
    cycle(1'b1, BURST, 1'b1, 4'hF, 1'b0, 2'd0, 8'h00);
    run_cycles(3, BURST, 4'hF);

    rm = RUN;
    for (int i = 0; i < 600; i++) begin
      logic ld;
      logic [7:0] sv;
      if ($urandom_range(0, 7) == 0) rm = rng_mode_e'($urandom_range(0, 3));
      ld = ($urandom_range(0, 7) == 0);
      sv = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cycle(($urandom_range(0, 99) == 0), rm, 1'($urandom_range(0, 1)),
            4'($urandom), ld, 2'($urandom), sv);
    end

    drain = 0;
    while (expq.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);

    // Six-lane instance: seed_ch values 6 and 7 have no lane behind them.
    @(negedge clk);
    reset_b = 1'b0;
    after_edge();
    chk("six_reset_seeds", 64'(bus_b.random_bus), 64'h0D0B09070503);
    @(negedge clk);
    bus_b.seed_load = 1'b1; bus_b.seed_ch = 3'd6; bus_b.seed_value = 8'h00;
    after_edge();
    chk("oor6_bus", 64'(bus_b.random_bus), 64'h0D0B09070503);
    chk("oor6_valid", 64'(bus_b.valid), 64'd0);
    chk("oor6_zfix", 64'(bus_b.seed_zero_fix), 64'd0);
    @(negedge clk);
    bus_b.seed_ch = 3'd7; bus_b.seed_value = 8'h55;
    after_edge();
    chk("oor7_bus", 64'(bus_b.random_bus), 64'h0D0B09070503);
    chk("oor7_valid", 64'(bus_b.valid), 64'd0);
    @(negedge clk);
    bus_b.seed_ch = 3'd5; bus_b.seed_value = 8'h00;
    after_edge();
    chk("ch5_zero_load", 64'(bus_b.random_bus), 64'h010B09070503);
    chk("ch5_zfix", 64'(bus_b.seed_zero_fix), 64'd1);
    chk("ch5_valid", 64'(bus_b.valid), 64'd1);
    @(negedge clk);
    bus_b.seed_load = 1'b0;
    after_edge();
    chk("ch5_zfix_oneshot", 64'(bus_b.seed_zero_fix), 64'd0);
    chk("hold_valid_idle", 64'(bus_b.valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
